// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg -- shared definitions for the execute stage: bus widths,
// field offsets, ALU/divider op bit indices and divider FSM encodings.
// The optional iterative divider is built only when EXE_DIV_EN is defined.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 152;
    localparam int ES_TO_MS_BUS_WD = 71;

    // ds_to_es_bus field LSB offsets (MSB->LSB: pc, alu_op, src1, src2, rkd, dest, flags, div_op)
    localparam int DS_PC_LSB           = 120;
    localparam int DS_ALU_OP_LSB       = 108;
    localparam int DS_SRC1_LSB         = 76;
    localparam int DS_SRC2_LSB         = 44;
    localparam int DS_RKD_LSB          = 12;
    localparam int DS_DEST_LSB         = 7;
    localparam int DS_GR_WE_BIT        = 6;
    localparam int DS_MEM_WE_BIT       = 5;
    localparam int DS_RES_FROM_MEM_BIT = 4;
    localparam int DS_DIV_OP_LSB       = 0;

    // es_to_ms_bus field LSB offsets (MSB->LSB: pc, result, dest, gr_we, res_from_mem)
    localparam int ES_PC_LSB           = 39;
    localparam int ES_RESULT_LSB       = 7;
    localparam int ES_DEST_LSB         = 2;
    localparam int ES_GR_WE_BIT        = 1;
    localparam int ES_RES_FROM_MEM_BIT = 0;

    // div_op one-hot bit indices
    localparam int DIV_OP_DIV_W  = 0;
    localparam int DIV_OP_MOD_W  = 1;
    localparam int DIV_OP_DIV_WU = 2;
    localparam int DIV_OP_MOD_WU = 3;

    // alu_op one-hot bit indices
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [31:0] rkd_value;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_we;
        logic        res_from_mem;
        logic [3:0]  div_op;
    } ds_to_es_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] es_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_mem;
    } es_to_ms_t;

endpackage

// File: rtl/alu.sv
// alu -- single-cycle integer ALU with one-hot operation select.
module alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic        use_sub;
    logic [31:0] adder_b;
    logic [32:0] adder_full;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sra_res;

    // Shared adder: subtraction and both compares use a + ~b + 1
    always_comb begin
        use_sub    = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
        adder_b    = use_sub ? ~alu_src2 : alu_src2;
        adder_full = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};
        slt_res    = (alu_src1[31] & ~alu_src2[31])
                   | (~(alu_src1[31] ^ alu_src2[31]) & adder_full[31]);
        sltu_res   = ~adder_full[32];
        sra_res    = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
    end

    // One-hot result mux
    always_comb begin
        alu_result = '0;
        alu_result |= {32{alu_op[ALU_ADD] | alu_op[ALU_SUB]}} & adder_full[31:0];
        alu_result |= {32{alu_op[ALU_SLT]}}  & {31'd0, slt_res};
        alu_result |= {32{alu_op[ALU_SLTU]}} & {31'd0, sltu_res};
        alu_result |= {32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2);
        alu_result |= {32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2);
        alu_result |= {32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2);
        alu_result |= {32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2);
        alu_result |= {32{alu_op[ALU_SLL]}}  & (alu_src1 << alu_src2[4:0]);
        alu_result |= {32{alu_op[ALU_SRL]}}  & (alu_src1 >> alu_src2[4:0]);
        alu_result |= {32{alu_op[ALU_SRA]}}  & sra_res;
        alu_result |= {32{alu_op[ALU_LUI]}}  & alu_src2;
    end

endmodule

// File: rtl/exe_stage_div_iter.sv
// div_iter -- 32-step restoring divider (one quotient bit per cycle).
// Signed operation divides magnitudes and fixes signs on the output.
// Only instantiated by exe_stage when EXE_DIV_EN is defined.
module div_iter
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        ack,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] quot_reg;      // holds remaining dividend bits, shifted out MSB first
    logic [31:0] rem_reg;
    logic [31:0] dsor_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;

    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [32:0] shifted;
    logic [32:0] trial;

    // Operand magnitudes and one restoring trial subtraction
    always_comb begin
        dividend_mag = (is_signed & dividend[31]) ? (~dividend + 32'd1) : dividend;
        divisor_mag  = (is_signed & divisor[31])  ? (~divisor + 32'd1)  : divisor;
        shifted      = {rem_reg, quot_reg[31]};
        trial        = shifted - {1'b0, dsor_reg};
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= DIV_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DIV_IDLE: if (start) state_next = DIV_BUSY;
            DIV_BUSY: if (count_reg == 5'd31) state_next = DIV_DONE;
            DIV_DONE: if (ack) state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_reg == DIV_BUSY);
        done = (state_reg == DIV_DONE);
    end

    // Datapath: load operands on start, one restoring step per BUSY cycle.
    // A zero divisor never borrows, so the quotient fills with ones and the
    // remainder ends up as the dividend magnitude; suppressing the quotient
    // negation then yields all-ones / dividend for signed ops too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dsor_reg  <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (state_reg == DIV_IDLE && start) begin
            count_reg <= '0;
            quot_reg  <= dividend_mag;
            rem_reg   <= '0;
            dsor_reg  <= divisor_mag;
            neg_q_reg <= is_signed & (dividend[31] ^ divisor[31]) & (divisor != 32'd0);
            neg_r_reg <= is_signed & dividend[31];
        end else if (state_reg == DIV_BUSY) begin
            count_reg <= count_reg + 5'd1;
            quot_reg  <= {quot_reg[30:0], ~trial[32]};
            rem_reg   <= trial[32] ? shifted[31:0] : trial[31:0];
        end
    end

    // Sign correction of the final magnitudes
    always_comb begin
        quotient  = neg_q_reg ? (~quot_reg + 32'd1) : quot_reg;
        remainder = neg_r_reg ? (~rem_reg + 32'd1)  : rem_reg;
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage -- pipeline execute stage: ALU, data SRAM request, forwarding
// info, and (when EXE_DIV_EN is defined) an iterative 32-bit divider that
// stalls the stage until the result is ready.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_allowin,
    input  logic                       ms_allowin,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic                       es_fwd_valid,
    output logic [4:0]                 es_fwd_dest,
    output logic [31:0]                es_fwd_result,
    output logic                       es_fwd_is_load
);

    logic        es_valid_reg;
    ds_to_es_t   ds_bus_reg;
    logic        es_ready_go;
    logic        div_active;
    logic [31:0] alu_result;
    logic [31:0] es_result;
    es_to_ms_t   es_out;

    // Stage valid bit: advances whenever the stage accepts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_reg <= 1'b0;
        end else if (es_allowin) begin
            es_valid_reg <= ds_to_es_valid;
        end
    end

    // Instruction bus register: loads only on a real handoff; outputs are
    // qualified by es_valid_reg, so no reset is needed here
    always_ff @(posedge clk) begin
        if (ds_to_es_valid && es_allowin) begin
            ds_bus_reg <= ds_to_es_t'(ds_to_es_bus);
        end
    end

    alu u_alu (
        .alu_op     (ds_bus_reg.alu_op),
        .alu_src1   (ds_bus_reg.alu_src1),
        .alu_src2   (ds_bus_reg.alu_src2),
        .alu_result (alu_result)
    );

`ifdef EXE_DIV_EN
    logic        div_signed;
    logic        div_want_quot;
    logic        div_done;
    logic        unused_div_busy;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    assign div_active    = es_valid_reg & (|ds_bus_reg.div_op);
    assign div_signed    = ds_bus_reg.div_op[DIV_OP_DIV_W]  | ds_bus_reg.div_op[DIV_OP_MOD_W];
    assign div_want_quot = ds_bus_reg.div_op[DIV_OP_DIV_W]  | ds_bus_reg.div_op[DIV_OP_DIV_WU];

    div_iter u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_active),
        .ack       (es_to_ms_valid & ms_allowin),
        .is_signed (div_signed),
        .dividend  (ds_bus_reg.alu_src1),
        .divisor   (ds_bus_reg.alu_src2),
        .busy      (unused_div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign es_ready_go = ~div_active | div_done;
    assign es_result   = div_active ? (div_want_quot ? div_quotient : div_remainder)
                                    : alu_result;
`else
    logic unused_div_op;

    assign div_active    = 1'b0;
    assign unused_div_op = ^ds_bus_reg.div_op;
    assign es_ready_go   = ~div_active;
    assign es_result     = alu_result;
`endif

    // Handshake, result bus, memory request and forwarding outputs
    always_comb begin
        es_allowin     = ~es_valid_reg | (es_ready_go & ms_allowin);
        es_to_ms_valid = es_valid_reg & es_ready_go;

        es_out.pc           = ds_bus_reg.pc;
        es_out.es_result    = es_result;
        es_out.dest         = ds_bus_reg.dest;
        es_out.gr_we        = ds_bus_reg.gr_we;
        es_out.res_from_mem = ds_bus_reg.res_from_mem;
        es_to_ms_bus        = es_valid_reg ? es_out : '0;

        // Request only on the handoff cycle so a stalled access is never repeated
        data_sram_en    = es_valid_reg & es_ready_go & ms_allowin
                        & (ds_bus_reg.mem_we | ds_bus_reg.res_from_mem);
        data_sram_we    = {4{data_sram_en & ds_bus_reg.mem_we}};
        data_sram_addr  = es_valid_reg ? alu_result : '0;
        data_sram_wdata = es_valid_reg ? ds_bus_reg.rkd_value : '0;

        es_fwd_valid    = es_valid_reg & ds_bus_reg.gr_we & (ds_bus_reg.dest != 5'd0);
        es_fwd_dest     = es_valid_reg ? ds_bus_reg.dest : '0;
        es_fwd_result   = es_valid_reg ? es_result : '0;
        es_fwd_is_load  = es_valid_reg & ds_bus_reg.res_from_mem;
    end

endmodule
